mem_access_unit: RTL and testbench
==================================

# mem_access_unit

CPU-side initiator for the word-wide, little-endian data memory. Accepts one load/store request at a time from the MEM stage, handles byte/halfword/word sizing, performs read-modify-write for sub-word stores (the memory only writes whole words), and sign/zero-extends load results. It sits between the pipeline's MEM stage and the data memory, driving the memory's address, write data, and read/write strobes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only in IDLE.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 = byte, 01 = half, 10/11 = word.
- reqSigned  in  1  load sign-extend enable; ignored for stores and words.
- reqAddr  in  32  byte address.
- reqData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- loadData  out  32  extended load result; valid while done=1, otherwise holds its value.
- misalign  out  1  high with done when the request was rejected (see Configuration).
- memAddr  out  32  word address to memory; bits [1:0] always 0.
- memWriteData  out  32  full word to write.
- memRead  out  1  read strobe; memory returns memReadData combinationally.
- memWrite  out  1  write strobe; the memory commits at the clock edge ending that cycle.
- memReadData  in  32  word from memory; byte k occupies bits [8k+7:8k].

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + req=1: latch reqWrite, reqSize, reqSigned, reqAddr, reqData.
  - Load → READ.
  - Word store → WRITE.
  - Sub-word store → READ.
- IDLE + req=0: stay in IDLE.
- READ: drive memRead=1 and memAddr={addr[31:2],2'b00}; capture memReadData at the end of the cycle.
  - Load → DONE.
  - Sub-word store → WRITE.
- WRITE: drive memWrite=1 and memWriteData.
  - Word store: memWriteData = latched data.
  - Sub-word store: captured word with the target lane replaced by the store data.
  - Next state: DONE.
- DONE: done=1 for one cycle → IDLE.
- Lane select:
  - Byte lane b = addr[1:0] occupies bits [8b+7:8b].
  - Half lane h = addr[1] occupies bits [16h+15:16h].
- Load extension:
  - Byte/half: sign-extend from the lane MSB when reqSigned=1, otherwise zero-extend.
  - Word: passed through unchanged.
- memRead and memWrite are never both high. Both are 0 in IDLE and DONE.
- req while busy=1, including the DONE cycle, is ignored. The requester waits for done and then re-presents.

## Timing
- Request accepted at the edge ending cycle N:
  - Load: done in cycle N+2.
  - Word store: done in cycle N+2 (memWrite in N+1).
  - Sub-word store: memRead in N+1, memWrite in N+2, done in N+3.
  - Rejected misaligned request: done and misalign in cycle N+1, with no memory strobe.
- Reset values: state=IDLE; busy, done, misalign, memRead, memWrite = 0; memAddr, memWriteData, loadData = 0.
- Reset mid-operation: the FSM returns to IDLE at the next edge and pending work is discarded, so no later memWrite is issued. A WRITE cycle concurrent with rst=1 still commits.
- Throughput: at most one request per 3 cycles (load/word store) or per 4 cycles (sub-word store).

## Configuration
- MAU_MISALIGN_TRAP_EN defined: a request is misaligned if it is a half with addr[0]=1 or a word with addr[1:0]≠0.
  - A misaligned request goes IDLE→DONE with misalign=1 and loadData=0, and performs no memory access.
- MAU_MISALIGN_TRAP_EN undefined: misalign is tied to 0.
  - Halves ignore addr[0]; words ignore addr[1:0] (lane forced aligned).
  - Timing is unchanged.

## Test plan
Memory word at 0x10 is preloaded to 0x8899AABB for all scenarios.
- Signed byte load at 0x11 → loadData=0xFFFFFFAA in cycle N+2. Unsigned byte load at the same address → 0x000000AA.
- Signed half load at 0x12 → 0xFFFF8899. Unsigned half load at 0x10 → 0x0000AABB. Word load at 0x10 → 0x8899AABB.
- Byte store at 0x13 with reqData=0x12345677 → memRead in N+1, memWrite with 0x7799AABB at memAddr 0x10 in N+2, done in N+3. Half store of 0x0000CDEF at 0x10 → 0x8899CDEF.
- Word store of 0xDEADBEEF at 0x10 → memWrite in N+1, done in N+2. A subsequent word load returns 0xDEADBEEF. A req held high during busy produces exactly one access.
- Word load at 0x12:
  - MAU_MISALIGN_TRAP_EN defined: done=1 and misalign=1 in N+1, no memRead.
  - Undefined: load from 0x10 returns 0x8899AABB.
- rst=1 during the READ cycle of a byte store → no memWrite follows, all outputs 0 next cycle, and the word at 0x10 is unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side initiator for the word-wide little-endian data memory.
// Handles byte/half/word sizing, read-modify-write for sub-word stores and
// sign/zero extension of loads. All outputs are registered.
// Optional feature: define MAU_MISALIGN_TRAP_EN to reject misaligned half/word
// requests (IDLE->DONE with misalign=1, no memory access). Otherwise misalign
// stays 0 and the lane is simply forced aligned.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        misalign,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        latWrite;
  logic [1:0]  latSize;
  logic        latSigned;
  logic [1:0]  latLane;
  logic [15:0] latData;   // only sub-word stores need the latched data
  logic        reqMis;

`ifdef MAU_MISALIGN_TRAP_EN
  assign reqMis = ((reqSize == 2'b01) && reqAddr[0]) ||
                  (reqSize[1] && (reqAddr[1:0] != 2'b00));
`else
  assign reqMis = 1'b0;
`endif

  // Pick the addressed lane out of the word and extend it to 32 bits.
  function automatic logic [31:0] extendLoad(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    case (ln)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00)      extendLoad = {{24{sg & b[7]}}, b};
    else if (sz == 2'b01) extendLoad = {{16{sg & h[15]}}, h};
    else                  extendLoad = w;
  endfunction

  // Replace the addressed byte/half lane of the read word with store data.
  function automatic logic [31:0] mergeStore(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] ln, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (ln)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (ln[1]) begin
      r[31:16] = d;
    end else begin
      r[15:0] = d;
    end
    mergeStore = r;
  endfunction

  // Request FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      misalign     <= 1'b0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      memAddr      <= '0;
      memWriteData <= '0;
      loadData     <= '0;
      latWrite     <= 1'b0;
      latSize      <= 2'b00;
      latSigned    <= 1'b0;
      latLane      <= 2'b00;
      latData      <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          busy      <= 1'b1;
          latWrite  <= reqWrite;
          latSize   <= reqSize;
          latSigned <= reqSigned;
          latLane   <= reqAddr[1:0];
          latData   <= reqData[15:0];
          memAddr   <= {reqAddr[31:2], 2'b00};
          if (reqMis) begin
            state    <= DONE;
            done     <= 1'b1;
            misalign <= 1'b1;
            loadData <= '0;
          end else if (reqWrite && reqSize[1]) begin
            state        <= WRITE;
            memWrite     <= 1'b1;
            memWriteData <= reqData;
          end else begin
            state   <= READ;
            memRead <= 1'b1;
          end
        end
        READ: begin
          memRead <= 1'b0;
          if (latWrite) begin
            state        <= WRITE;
            memWrite     <= 1'b1;
            memWriteData <= mergeStore(memReadData, latSize, latLane, latData);
          end else begin
            state    <= DONE;
            done     <= 1'b1;
            loadData <= extendLoad(memReadData, latSize, latSigned, latLane);
          end
        end
        WRITE: begin
          memWrite <= 1'b0;
          state    <= DONE;
          done     <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          misalign <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized + directed bench for mem_access_unit against a
// byte-array reference model of the data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, req, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqData;
  logic        busy, done, misalign, memRead, memWrite;
  logic [31:0] loadData, memAddr, memWriteData, memReadData;
  logic        initMem;

  logic [31:0] mem [0:63];
  logic [7:0]  refByte [0:255];
  int total = 0;
  int bad = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req(req), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData), .busy(busy),
    .done(done), .loadData(loadData), .misalign(misalign), .memAddr(memAddr),
    .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite),
    .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h01030507) ^ 32'hC35A96E1;
  endfunction

  // Data memory: combinational read, write commits at the clock edge.
  assign memReadData = mem[memAddr[7:2]];
  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
    end else if (memWrite) begin
      mem[memAddr[7:2]] <= memWriteData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic refInit();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = initWord(i);
      for (int k = 0; k < 4; k++) refByte[4*i+k] = w[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] refWord(input int idx);
    return {refByte[4*idx+3], refByte[4*idx+2], refByte[4*idx+1], refByte[4*idx]};
  endfunction

  function automatic bit isMis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MAU_MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Load value from the byte array: aligned to its size, then extended arithmetically.
  function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n, base;
    longint v;
    n = sizeBytes(sz);
    base = int'(a[7:0]);
    base = base - (base % n);
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(refByte[base+k]) << (8*k));
    if (sg && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic refStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n, base;
    n = sizeBytes(sz);
    base = int'(a[7:0]);
    base = base - (base % n);
    for (int k = 0; k < n; k++) refByte[base+k] = d[8*k +: 8];
  endtask

  task automatic reinit();
    @(negedge clk); initMem = 1'b1;
    @(negedge clk); initMem = 1'b0;
    refInit();
  endtask

  // One request, observed for six cycles after acceptance (cycle 1 = N+1).
  task automatic doOp(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d, input bit hold);
    bit mis, sub;
    int expDone, expRd, expWr;
    int rdAt, rdCnt, wrAt, wrCnt, doneAt, doneCnt;
    logic [31:0] expLd, expWd, alignedA;
    mis = isMis(sz, a);
    sub = w && !sz[1];
    expDone = mis ? 1 : (sub ? 3 : 2);
    expRd = (mis || (w && !sub)) ? 0 : 1;
    expWr = (mis || !w) ? 0 : (sub ? 2 : 1);
    expLd = mis ? 32'h0 : refLoad(sz, sg, a);
    alignedA = {a[31:2], 2'b00};
    if (w && !mis) refStore(sz, a, d);
    expWd = refWord(int'(a[7:2]));
    rdAt = 0; rdCnt = 0; wrAt = 0; wrCnt = 0; doneAt = 0; doneCnt = 0;

    @(negedge clk);
    req = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      chk("rdWrExcl", {31'b0, memRead & memWrite}, 32'h0);
      chk("busy", {31'b0, busy}, (c <= expDone) ? 32'h1 : 32'h0);
      if (memRead) begin
        rdCnt++; rdAt = c;
        chk("rdAddr", memAddr, alignedA);
      end
      if (memWrite) begin
        wrCnt++; wrAt = c;
        chk("wrAddr", memAddr, alignedA);
        chk("wrData", memWriteData, expWd);
      end
      if (done) begin
        doneCnt++; doneAt = c;
        req = 1'b0;
        chk("misalign", {31'b0, misalign}, {31'b0, mis});
        if (!w || mis) chk("loadData", loadData, expLd);
      end
    end
    req = 1'b0;
    chk("rdAt", rdAt, expRd);
    chk("rdCnt", rdCnt, (expRd != 0) ? 1 : 0);
    chk("wrAt", wrAt, expWr);
    chk("wrCnt", wrCnt, (expWr != 0) ? 1 : 0);
    chk("doneAt", doneAt, expDone);
    chk("doneCnt", doneCnt, 1);
    chk("memWord", mem[a[7:2]], refWord(int'(a[7:2])));
  endtask

  task automatic chkIdleZero(input string tag);
    chk({tag, ".busy"}, {31'b0, busy}, 32'h0);
    chk({tag, ".done"}, {31'b0, done}, 32'h0);
    chk({tag, ".mis"}, {31'b0, misalign}, 32'h0);
    chk({tag, ".rd"}, {31'b0, memRead}, 32'h0);
    chk({tag, ".wr"}, {31'b0, memWrite}, 32'h0);
    chk({tag, ".addr"}, memAddr, 32'h0);
    chk({tag, ".wdata"}, memWriteData, 32'h0);
    chk({tag, ".ld"}, loadData, 32'h0);
  endtask

  initial begin
    int wrSeen;
    rst = 1'b1; req = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = '0; reqData = '0; initMem = 1'b1;
    refInit();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkIdleZero("reset");
    rst = 1'b0; initMem = 1'b0;

    // Loads from the preloaded word 0x8899AABB at 0x10.
    doOp(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0); chk("ldSB", loadData, 32'hFFFFFFAA);
    doOp(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0); chk("ldUB", loadData, 32'h000000AA);
    doOp(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0); chk("ldSH", loadData, 32'hFFFF8899);
    doOp(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0); chk("ldUH", loadData, 32'h0000AABB);
    doOp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0); chk("ldW",  loadData, 32'h8899AABB);

    // Sub-word stores (read-modify-write).
    doOp(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345677, 1'b0); chk("stB", mem[4], 32'h7799AABB);
    reinit();
    doOp(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000CDEF, 1'b0); chk("stH", mem[4], 32'h8899CDEF);
    reinit();

    // Word store with req held high, then read it back.
    doOp(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1); chk("stW", mem[4], 32'hDEADBEEF);
    doOp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0); chk("ldWback", loadData, 32'hDEADBEEF);
    reinit();

    // Misaligned word load.
    doOp(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("misLd", loadData, 32'h0);
`else
    chk("misLd", loadData, 32'h8899AABB);
`endif

    // Reset during the READ cycle of a byte store.
    @(negedge clk);
    req = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'h13; reqData = 32'h12345677;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rstRd", {31'b0, memRead}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chkIdleZero("midRst");
    wrSeen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (memWrite) wrSeen++;
    end
    chk("rstNoWr", wrSeen, 0);
    chk("rstWord", mem[4], 32'h8899AABB);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 15) == 0 ? $urandom() : 32'h0};
      a[7:0] = 8'($urandom_range(0, 255));
      doOp(1'($urandom()), 2'($urandom()), 1'($urandom()), a, $urandom(),
           1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
